// File: rtl/store_unit.sv
// Store execution stage: pops ready stores, reports completion, waits for ROB commit, writes memory.
// Define STORE_UNIT_TIMEOUT_EN to add the MEM-phase watchdog and the sticky mem_error output.
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif

module store_unit #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          sb_valid,
  input  logic [$clog2(`ROB_LENGTH)-1:0] sb_rob_addr,
  input  logic [$clog2(`NUM_D_REG)-1:0]  sb_ra_addr,
  input  logic [$clog2(`NUM_D_REG)-1:0]  sb_rt_addr,
  input  logic                          sb_retain,
  output logic                          sb_pop,
  output logic [$clog2(`NUM_D_REG)-1:0]  rf_ra_addr,
  output logic [$clog2(`NUM_D_REG)-1:0]  rf_rt_addr,
  input  logic [DATA_W-1:0]             rf_ra_data,
  input  logic [DATA_W-1:0]             rf_rt_data,
  output logic                          complete_valid,
  output logic [$clog2(`ROB_LENGTH)-1:0] complete_rob_addr,
  input  logic                          commit_valid,
  input  logic [$clog2(`ROB_LENGTH)-1:0] commit_rob_addr,
  input  logic                          flush,
  output logic                          mem_req,
  output logic [DATA_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ready,
`ifdef STORE_UNIT_TIMEOUT_EN
  output logic                          busy,
  output logic                          mem_error
`else
  output logic                          busy
`endif
);

  localparam int ROB_W = $clog2(`ROB_LENGTH);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPLETE    = 2'd1,
    WAIT_COMMIT = 2'd2,
    MEM         = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ROB_W-1:0]   rob_q, rob_d;
  logic [DATA_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               tmo;

  assign rf_ra_addr        = sb_ra_addr;
  assign rf_rt_addr        = sb_rt_addr;
  assign complete_rob_addr = rob_q;
  assign mem_addr          = addr_q;
  assign mem_wdata         = data_q;
  assign busy              = (state_q != IDLE);

`ifdef STORE_UNIT_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter sits at zero outside MEM, so it is already clear on entry.
  always_comb begin
    cnt_d = '0;
    tmo   = 1'b0;
    if (state_q == MEM && !mem_ready) begin
      cnt_d = cnt_q + CNT_W'(1);
      tmo   = (cnt_d == CNT_W'(TIMEOUT));
    end
    err_d = err_q | tmo;
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign mem_error = err_q;
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_d        = state_q;
    rob_d          = rob_q;
    addr_d         = addr_q;
    data_d         = data_q;
    sb_pop         = 1'b0;
    complete_valid = 1'b0;
    mem_req        = 1'b0;
    unique case (state_q)
      IDLE: begin
        sb_pop = ~flush;
        if (!flush && sb_valid && !sb_retain) begin
          rob_d   = sb_rob_addr;
          addr_d  = rf_ra_data;
          data_d  = rf_rt_data;
          state_d = COMPLETE;
        end
      end
      COMPLETE: begin
        if (flush) begin
          state_d = IDLE;
        end else begin
          complete_valid = 1'b1;
          state_d        = WAIT_COMMIT;
        end
      end
      WAIT_COMMIT: begin
        // Flush wins over a same-cycle matching commit.
        if (flush) begin
          state_d = IDLE;
        end else if (commit_valid && commit_rob_addr == rob_q) begin
          state_d = MEM;
        end
      end
      MEM: begin
        // Already committed: flush cannot cancel the write.
        mem_req = 1'b1;
        if (mem_ready || tmo) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_q <= IDLE;
      rob_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rob_q   <= rob_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: tb/tb_store_unit.sv
// Testbench for store_unit: vector table, directed corner sequences, randomized run against a transaction model.
`ifndef ROB_LENGTH
`define ROB_LENGTH 16
`endif
`ifndef NUM_D_REG
`define NUM_D_REG 32
`endif

module tb_store_unit;

  localparam int DW    = 16;
  localparam int ROB_W = $clog2(`ROB_LENGTH);
  localparam int REG_W = $clog2(`NUM_D_REG);
`ifdef STORE_UNIT_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 64;
`endif

  logic             clk = 1'b0;
  logic             n_rst;
  logic             sb_valid, sb_retain, sb_pop;
  logic [ROB_W-1:0] sb_rob_addr, complete_rob_addr, commit_rob_addr;
  logic [REG_W-1:0] sb_ra_addr, sb_rt_addr, rf_ra_addr, rf_rt_addr;
  logic [DW-1:0]    rf_ra_data, rf_rt_data, mem_addr, mem_wdata;
  logic             complete_valid, commit_valid, flush;
  logic             mem_req, mem_ready, busy;
`ifdef STORE_UNIT_TIMEOUT_EN
  logic             mem_error;
`endif

  logic [DW-1:0] regs [`NUM_D_REG];
  assign rf_ra_data = regs[rf_ra_addr];
  assign rf_rt_data = regs[rf_rt_addr];

  always #5 clk = ~clk;

  store_unit #(.DATA_W(DW), .TIMEOUT(TMO)) dut (
    .clk(clk), .n_rst(n_rst),
    .sb_valid(sb_valid), .sb_rob_addr(sb_rob_addr),
    .sb_ra_addr(sb_ra_addr), .sb_rt_addr(sb_rt_addr),
    .sb_retain(sb_retain), .sb_pop(sb_pop),
    .rf_ra_addr(rf_ra_addr), .rf_rt_addr(rf_rt_addr),
    .rf_ra_data(rf_ra_data), .rf_rt_data(rf_rt_data),
    .complete_valid(complete_valid), .complete_rob_addr(complete_rob_addr),
    .commit_valid(commit_valid), .commit_rob_addr(commit_rob_addr),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
`ifdef STORE_UNIT_TIMEOUT_EN
    .busy(busy), .mem_error(mem_error)
`else
    .busy(busy)
`endif
  );

  typedef struct {
    logic v, ret; logic [3:0] rob; logic [4:0] ra, rt;
    logic cmv; logic [3:0] cmt; logic fl, rdy;
    logic pop, cv; logic [3:0] cvt; logic req; logic [15:0] addr, wd; logic bsy;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int failures = 0;

  function automatic vec_t mk(input logic v, ret, input logic [3:0] rob, input logic [4:0] ra, rt,
                              input logic cmv, input logic [3:0] cmt, input logic fl, rdy,
                              input logic pop, cv, input logic [3:0] cvt, input logic req,
                              input logic [15:0] addr, wd, input logic bsy);
    vec_t r;
    r.v = v; r.ret = ret; r.rob = rob; r.ra = ra; r.rt = rt;
    r.cmv = cmv; r.cmt = cmt; r.fl = fl; r.rdy = rdy;
    r.pop = pop; r.cv = cv; r.cvt = cvt; r.req = req; r.addr = addr; r.wd = wd; r.bsy = bsy;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    sb_valid = 0; sb_retain = 0; sb_rob_addr = '0; sb_ra_addr = '0; sb_rt_addr = '0;
    commit_valid = 0; commit_rob_addr = '0; flush = 0; mem_ready = 0;
  endtask

  // Transaction-level model state for the randomized phase.
  bit            m_out, m_committed;
  int            m_age, m_wait, m_writes;
  logic [3:0]    m_rob;
  logic [15:0]   m_addr, m_data;
  logic          e_pop, e_cv, e_req;

  initial begin
    for (int i = 0; i < `NUM_D_REG; i++) regs[i] = 16'($urandom);
    regs[1] = 16'h1234; regs[2] = 16'h5678; regs[3] = 16'h0040; regs[5] = 16'hBEEF;

    //            v ret rob ra rt cmv cmt fl rdy  pop cv cvt req addr     wd       bsy
    // basic store: accept, complete, commit, write, idle
    tbl.push_back(mk(1,0,7,3,5, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,1,7,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,7,0,0, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1, 0,0,0,1,16'h0040,16'hBEEF,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    // retain blocks acceptance
    tbl.push_back(mk(1,1,2,3,5, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(1,1,2,3,5, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    // foreign commit tags ignored
    tbl.push_back(mk(1,0,7,1,2, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,1,7,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,6,0,1, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,8,0,1, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,7,0,0, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1, 0,0,0,1,16'h1234,16'h5678,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    // flush in WAIT_COMMIT beats a matching commit
    tbl.push_back(mk(1,0,3,3,5, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,1,3,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,3,1,0, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1, 1,0,0,0,16'h0,16'h0,0));
    // flush in COMPLETE suppresses complete_valid
    tbl.push_back(mk(1,0,4,1,2, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,4,0,1, 1,0,0,0,16'h0,16'h0,0));
    // flush in IDLE blocks acceptance
    tbl.push_back(mk(1,0,5,3,5, 0,0,1,0, 0,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    // flush in MEM does not cancel the write
    tbl.push_back(mk(1,0,9,3,5, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,1,9,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,9,0,0, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,1,0, 0,0,0,1,16'h0040,16'hBEEF,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1, 0,0,0,1,16'h0040,16'hBEEF,1));
    // accept in the cycle the previous store returns to IDLE
    tbl.push_back(mk(1,0,1,1,2, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 0,1,1,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 1,1,0,0, 0,0,0,0,16'h0,16'h0,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,1, 0,0,0,1,16'h1234,16'h5678,1));
    tbl.push_back(mk(0,0,0,0,0, 0,0,0,0, 1,0,0,0,16'h0,16'h0,0));

    idle_inputs();
    n_rst = 0;
    tick(); tick();
    n_rst = 1;
    #1;
    chk("reset_sb_pop", sb_pop, 1);
    chk("reset_complete_valid", complete_valid, 0);
    chk("reset_mem_req", mem_req, 0);
    chk("reset_busy", busy, 0);
    chk("reset_mem_addr", mem_addr, 0);
    chk("reset_mem_wdata", mem_wdata, 0);
`ifdef STORE_UNIT_TIMEOUT_EN
    chk("reset_mem_error", mem_error, 0);
`endif

    foreach (tbl[i]) begin
      sb_valid = tbl[i].v; sb_retain = tbl[i].ret; sb_rob_addr = tbl[i].rob;
      sb_ra_addr = tbl[i].ra; sb_rt_addr = tbl[i].rt;
      commit_valid = tbl[i].cmv; commit_rob_addr = tbl[i].cmt;
      flush = tbl[i].fl; mem_ready = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_sb_pop", i), sb_pop, tbl[i].pop);
      chk($sformatf("vec%0d_complete_valid", i), complete_valid, tbl[i].cv);
      if (tbl[i].cv) chk($sformatf("vec%0d_complete_tag", i), complete_rob_addr, tbl[i].cvt);
      chk($sformatf("vec%0d_mem_req", i), mem_req, tbl[i].req);
      if (tbl[i].req) begin
        chk($sformatf("vec%0d_mem_addr", i), mem_addr, tbl[i].addr);
        chk($sformatf("vec%0d_mem_wdata", i), mem_wdata, tbl[i].wd);
      end
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      chk($sformatf("vec%0d_rf_ra_addr", i), rf_ra_addr, sb_ra_addr);
      chk($sformatf("vec%0d_rf_rt_addr", i), rf_rt_addr, sb_rt_addr);
      tick();
    end
    idle_inputs();

`ifndef STORE_UNIT_TIMEOUT_EN
    // mem_ready low for 10 MEM cycles: request and payload hold steady
    sb_valid = 1; sb_rob_addr = 10; sb_ra_addr = 2; sb_rt_addr = 1;
    tick();
    idle_inputs(); tick();
    commit_valid = 1; commit_rob_addr = 10; tick();
    idle_inputs();
    for (int k = 0; k < 10; k++) begin
      #1;
      chk($sformatf("stall%0d_mem_req", k), mem_req, 1);
      chk($sformatf("stall%0d_mem_addr", k), mem_addr, 16'h5678);
      chk($sformatf("stall%0d_mem_wdata", k), mem_wdata, 16'h1234);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("stall_final_mem_req", mem_req, 1);
    tick();
    mem_ready = 0;
    #1;
    chk("stall_after_busy", busy, 0);
    chk("stall_after_mem_req", mem_req, 0);
`endif

    // reset in WAIT_COMMIT abandons the store
    sb_valid = 1; sb_rob_addr = 11; sb_ra_addr = 3; sb_rt_addr = 5;
    tick();
    idle_inputs(); tick();
    n_rst = 0; tick();
    n_rst = 1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_sb_pop", sb_pop, 1);
    chk("midrst_mem_addr", mem_addr, 0);
    chk("midrst_mem_wdata", mem_wdata, 0);
    commit_valid = 1; commit_rob_addr = 11; tick();
    idle_inputs();
    #1;
    chk("midrst_no_mem_req", mem_req, 0);
    chk("midrst_still_idle", busy, 0);

`ifdef STORE_UNIT_TIMEOUT_EN
    // write times out after TMO MEM cycles without mem_ready
    sb_valid = 1; sb_rob_addr = 12; sb_ra_addr = 3; sb_rt_addr = 5;
    tick();
    idle_inputs(); tick();
    commit_valid = 1; commit_rob_addr = 12; tick();
    idle_inputs();
    for (int k = 0; k < TMO; k++) begin
      #1;
      chk($sformatf("tmo%0d_mem_req", k), mem_req, 1);
      chk($sformatf("tmo%0d_mem_error", k), mem_error, 0);
      tick();
    end
    #1;
    chk("tmo_busy", busy, 0);
    chk("tmo_mem_req", mem_req, 0);
    chk("tmo_mem_error", mem_error, 1);
    chk("tmo_sb_pop", sb_pop, 1);
    sb_valid = 1; sb_rob_addr = 13; sb_ra_addr = 1; sb_rt_addr = 2;
    tick();
    idle_inputs();
    #1;
    chk("tmo_next_complete", complete_valid, 1);
    chk("tmo_next_tag", complete_rob_addr, 13);
    tick();
    commit_valid = 1; commit_rob_addr = 13; tick();
    idle_inputs(); mem_ready = 1; tick();
    mem_ready = 0;
    #1;
    chk("tmo_error_sticky", mem_error, 1);
`endif

    // randomized traffic against the transaction model
    m_out = 0; m_committed = 0; m_age = 0; m_wait = 0; m_writes = 0;
    m_rob = '0; m_addr = '0; m_data = '0;
    for (int c = 0; c < 3000; c++) begin
      sb_valid        = ($urandom_range(0, 9) < 6);
      sb_retain       = ($urandom_range(0, 4) == 0);
      sb_rob_addr     = 4'($urandom);
      sb_ra_addr      = 5'($urandom);
      sb_rt_addr      = 5'($urandom);
      commit_valid    = ($urandom_range(0, 2) == 0);
      commit_rob_addr = ($urandom_range(0, 1) == 1) ? m_rob : 4'($urandom);
      flush           = ($urandom_range(0, 19) == 0);
      mem_ready       = ($urandom_range(0, 1) == 1);
      #1;
      e_pop = !m_out && !flush;
      e_cv  = m_out && (m_age == 1) && !flush;
      e_req = m_out && m_committed;
      chk("rnd_sb_pop", sb_pop, e_pop);
      chk("rnd_complete_valid", complete_valid, e_cv);
      if (e_cv) chk("rnd_complete_tag", complete_rob_addr, m_rob);
      chk("rnd_mem_req", mem_req, e_req);
      if (e_req) begin
        chk("rnd_mem_addr", mem_addr, m_addr);
        chk("rnd_mem_wdata", mem_wdata, m_data);
      end
      chk("rnd_busy", busy, m_out);

      if (!m_out) begin
        if (sb_valid && !sb_retain && !flush) begin
          m_out = 1; m_age = 1; m_committed = 0; m_wait = 0;
          m_rob = sb_rob_addr; m_addr = regs[sb_ra_addr]; m_data = regs[sb_rt_addr];
        end
      end else if (m_committed) begin
        if (mem_ready) begin
          m_writes++;
          m_out = 0;
        end else begin
          m_wait++;
`ifdef STORE_UNIT_TIMEOUT_EN
          if (m_wait == TMO) m_out = 0;
`endif
        end
      end else if (flush) begin
        m_out = 0;
      end else begin
        if (m_age >= 2 && commit_valid && commit_rob_addr == m_rob) m_committed = 1;
        m_age++;
      end
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
